seq_mult_32bit: RTL and testbench

SEQ_MULT_32BIT -- requirements
Module: seq_mult_32bit

---
 rtl/mult_pkg.sv | 20 ++
 rtl/add32_unit.sv | 17 +
 rtl/seq_mult_32bit.sv | 105 ++++++++++
 tb/tb_seq_mult_32bit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding, default operand width and iteration counter width.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    // Counter must reach WIDTH itself without wrapping.
    function automatic int unsigned mult_cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/add32_unit.sv
// Combinational WIDTH-bit adder with carry-in and carry-out; the only adder
// in the multiplier datapath.
module add32_unit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_mult_32bit.sv
// Sequential unsigned shift-add multiplier, one partial product per cycle.
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand skips CALC and
// goes straight to DONE with product 0.
module seq_mult_32bit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = mult_cnt_width(WIDTH);

    mult_state_t        r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_c;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH:0]     w_ca;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_last;

    add32_unit #(.WIDTH(WIDTH)) u_add (
        .a    (r_a),
        .b    (r_m),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // {C,A} is either A+M or A unchanged (C is always 0 between iterations),
    // then {C,A,Q} shifts right by one with zero fill.
    assign w_ca    = r_q[0] ? {w_cout, w_sum} : {r_c, r_a};
    assign w_a_nxt = w_ca[WIDTH:1];
    assign w_q_nxt = {w_ca[0], r_q[WIDTH-1:1]};
    assign w_last  = (r_count == CW'(WIDTH - 1));

    assign busy    = (r_state == ST_CALC);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

    // Control FSM and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_c       <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a       <= '0;
                        r_c       <= 1'b0;
                        r_q       <= multiplier;
                        r_m       <= multiplicand;
                        r_count   <= '0;
                        r_product <= '0;
`ifdef MULT_ZERO_BYPASS_EN
                        if ((multiplicand == '0) || (multiplier == '0))
                            r_state <= ST_DONE;
                        else
                            r_state <= ST_CALC;
`else
                        r_state   <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    r_a     <= w_a_nxt;
                    r_q     <= w_q_nxt;
                    r_c     <= 1'b0;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_product <= {w_a_nxt, w_q_nxt};
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_32bit.sv
// Directed self-checking bench for seq_mult_32bit. Latency is counted in
// edges after the start-sampling edge k; done "at edge k+n" means the
// sampled value at negedge n after edge k.
`timescale 1ns/1ps
module tb_seq_mult_32bit;

    localparam int unsigned W = 32;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult_32bit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Issue one start, scramble operands during CALC, optionally pulse a
    // second start at negedge inj_at, and wait (bounded) for done.
    task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                          input int inj_at, output int lat, output int busy_n,
                          output int unsigned done_cyc, output logic got);
        @(negedge clk);
        start = 1'b1; mcand = m; mplier = q;
        @(posedge clk);
        #1;
        start = 1'b0;
        mcand = ~m;
        mplier = q ^ 32'h5A5A_A5A5;
        check({tag, "_clr"}, {32'd0, product[63:32]} | {32'd0, product[31:0]}, 64'd0);
        lat = 0; busy_n = 0; got = 1'b0; done_cyc = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == inj_at) begin
                start = 1'b1; mcand = 32'd100; mplier = 32'd100;
            end else if (n == inj_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                lat = n; got = 1'b1; done_cyc = cyc;
                break;
            end
        end
        check({tag, "_done"}, {63'd0, got}, 64'd1);
    endtask

    task automatic do_vec(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [63:0] exp);
        int          lat, bn;
        int unsigned dc;
        logic        got;
        bit          zero_path;
        zero_path = BYPASS && ((m == '0) || (q == '0));
        run_op(tag, m, q, -5, lat, bn, dc, got);
        check({tag, "_lat"}, 64'(lat), zero_path ? 64'd1 : 64'd33);
        check({tag, "_busy"}, 64'(bn), zero_path ? 64'd0 : 64'd32);
        check({tag, "_prod"}, product, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int          lat, bn, extra;
        int unsigned dc0, dc1;
        logic        got;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_prod", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_vec("m3q5",   32'd3,          32'd5,          64'h0000_0000_0000_000F);
        do_vec("maxmax", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
        do_vec("one_max",32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF);
        do_vec("max_two",32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE);
        do_vec("p16p16", 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000);
        do_vec("msbmsb", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);

        // Second start 10 cycles into CALC must be ignored.
        run_op("ign", 32'd1000, 32'd1000, 10, lat, bn, dc0, got);
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_prod", product, 64'h0000_0000_000F_4240);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ign_extra_done", 64'(extra), 64'd0);
        check("ign_hold", product, 64'h0000_0000_000F_4240);

        // Reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; mcand = 32'd9; mplier = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(negedge clk);
        check("mid_busy_pre", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_done", {63'd0, done}, 64'd0);
        check("mid_prod", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("mid_no_done", 64'(extra), 64'd0);
        do_vec("m7q6", 32'd7, 32'd6, 64'd42);

        // Zero operands.
        do_vec("m0q9", 32'd0, 32'd9, 64'd0);
        do_vec("m5q0", 32'd5, 32'd0, 64'd0);

        // Back-to-back: restart in the first IDLE cycle after done.
        run_op("b2b1", 32'h0000_FFFF, 32'h0000_FFFF, -5, lat, bn, dc0, got);
        check("b2b1_prod", product, 64'h0000_0000_FFFE_0001);
        run_op("b2b2", 32'h10, 32'h20, -5, lat, bn, dc1, got);
        check("b2b2_prod", product, 64'h0000_0000_0000_0200);
        check("b2b_gap", 64'(dc1 - dc0), 64'd34);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
